// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: shared types for the FP unit scheduler.
//   fp_op_e     - 2-bit opcode carried from requesters to the shared FP unit.
//   sched_tag_t - {valid, id} entry of the in-flight tag pipe. ID_W is sized for
//                 the largest supported requester count (16), so one tag layout
//                 serves every N_REQ configuration.
package fp_sched_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned ID_W    = 4;

  typedef enum logic [1:0] {
    FP_ADD  = 2'd0,
    FP_SUB  = 2'd1,
    FP_MUL  = 2'd2,
    FP_RSVD = 2'd3
  } fp_op_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } sched_tag_t;

endpackage

// File: rtl/fp_rr_arb.sv
// fp_rr_arb: N-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (pointer returns to 0)
//   en         - grant enable; 0 forces grant to zero and freezes the pointer
//   req        - request vector
//   grant      - one-hot (or zero) combinational grant
//   win        - index of the highest-priority active request
//   hs         - a grant was given this cycle (req[win] & en)
module fp_rr_arb #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] win,
  output logic             hs
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_s;
  logic [PTR_W:0]   idx_s;
  logic             found_s;
  logic [N_REQ-1:0] grant_s;

  // Scan the request vector starting at the pointer, wrapping modulo N_REQ;
  // the first set bit found is the winner.
  always_comb begin
    found_s = 1'b0;
    win_s   = ptr_r;
    idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s   = {1'b0, ptr_r} + (PTR_W+1)'(i);
      idx_s   = (idx_s >= (PTR_W+1)'(N_REQ)) ? (idx_s - (PTR_W+1)'(N_REQ)) : idx_s;
      win_s   = (req[idx_s[PTR_W-1:0]] && !found_s) ? idx_s[PTR_W-1:0] : win_s;
      found_s = found_s | req[idx_s[PTR_W-1:0]];
    end
  end

  // One-hot grant for the winner, gated by en.
  always_comb begin
    grant_s        = '0;
    grant_s[win_s] = found_s & en;
  end

  // Pointer moves just past the winner on each handshake, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (found_s && en) begin
      ptr_r <= (win_s == PTR_W'(N_REQ-1)) ? '0 : (win_s + PTR_W'(1'b1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;
  assign win   = win_s;
  assign hs    = found_s & en;

endmodule

// File: rtl/fp_unit_sched.sv
// fp_unit_sched: round-robin scheduler sharing one fixed-latency FP pipeline
// between N_REQ requesters. A handshake in cycle T issues registered operands
// in T+1; the requester id follows the op through a LATENCY-deep tag pipe whose
// tail lines up with the unit result in T+1+LATENCY, and the registered
// response reaches the owner in T+2+LATENCY.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   en                   - issue enable (in-flight ops always complete)
//   req_valid/req_ready  - per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_op   - packed per-requester operands and opcode
//   unit_valid/a/b/op    - registered issue to the shared unit
//   unit_out_valid/result- result strobe and data from the shared unit
//   rsp_valid/rsp_data   - one-hot response strobe, broadcast data
//   idle                 - nothing pending anywhere (registered)
//   err                  - sticky tag/result alignment error
// Optional build macro FP_UNIT_SCHED_PERF_EN adds perf_grant_cnt (per-requester
// handshake counts, 32 bits each) and perf_wait_cnt (cycles with a request
// waiting without grant).
module fp_unit_sched
  import fp_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0] req_op,
  output logic               unit_valid,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  output logic [1:0]         unit_op,
  input  logic               unit_out_valid,
  input  logic [WIDTH-1:0]   unit_result,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               idle,
  output logic               err
`ifdef FP_UNIT_SCHED_PERF_EN
  ,
  output logic [N_REQ*32-1:0] perf_grant_cnt,
  output logic [31:0]         perf_wait_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   grant_s;
  logic [PTR_W-1:0]   win_s;
  logic               hs_s;

  logic               unit_valid_r;
  logic [WIDTH-1:0]   unit_a_r;
  logic [WIDTH-1:0]   unit_b_r;
  fp_op_e             unit_op_r;
  logic [ID_W-1:0]    issue_id_r;

  sched_tag_t [LATENCY-1:0] tag_r;
  sched_tag_t [LATENCY-1:0] tag_nxt_s;
  sched_tag_t         tail_s;
  logic               tag_busy_nxt_s;
  logic [N_REQ-1:0]   rsp_oh_s;

  logic [N_REQ-1:0]   rsp_valid_r;
  logic [WIDTH-1:0]   rsp_data_r;
  logic               idle_r;
  logic               err_r;

  fp_rr_arb #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req_valid),
    .grant (grant_s),
    .win   (win_s),
    .hs    (hs_s)
  );

  // Register the winner's operands; operands hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_valid_r <= 1'b0;
      unit_a_r     <= '0;
      unit_b_r     <= '0;
      unit_op_r    <= FP_ADD;
      issue_id_r   <= '0;
    end else begin
      unit_valid_r <= hs_s;
      if (hs_s) begin
        unit_a_r   <= req_a[win_s*WIDTH +: WIDTH];
        unit_b_r   <= req_b[win_s*WIDTH +: WIDTH];
        unit_op_r  <= fp_op_e'(req_op[win_s*2 +: 2]);
        issue_id_r <= ID_W'(win_s);
      end
    end
  end

  // Next tag-pipe contents and whether any op will still be in flight.
  always_comb begin
    tag_nxt_s      = '0;
    tag_nxt_s[0]   = {unit_valid_r, issue_id_r};
    for (int k = 1; k < LATENCY; k++) begin
      tag_nxt_s[k] = tag_r[k-1];
    end
    tag_busy_nxt_s = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      tag_busy_nxt_s = tag_busy_nxt_s | tag_nxt_s[k].valid;
    end
  end

  assign tail_s = tag_r[LATENCY-1];

  // Decode the tail id into the owner's response strobe (full id compared).
  always_comb begin
    rsp_oh_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_oh_s[i] = tail_s.valid & (tail_s.id == ID_W'(i));
    end
  end

  // Tag pipe shift, response routing, idle and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r       <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      idle_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      tag_r       <= tag_nxt_s;
      rsp_valid_r <= rsp_oh_s;
      if (tail_s.valid) begin
        rsp_data_r <= unit_result;
      end
      // Computed from next-state terms so idle rises the cycle after the
      // last response strobe.
      idle_r      <= ~hs_s & ~tag_busy_nxt_s & ~tail_s.valid;
      // Routing trusts the tag; a disagreeing strobe only flags the error.
      err_r       <= err_r | (tail_s.valid ^ unit_out_valid);
    end
  end

`ifdef FP_UNIT_SCHED_PERF_EN
  logic [N_REQ*32-1:0] perf_grant_r;
  logic [31:0]         perf_wait_r;

  // Wrapping handshake counters and waiting-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_r <= '0;
      perf_wait_r  <= 32'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_s[i]) begin
          perf_grant_r[i*32 +: 32] <= perf_grant_r[i*32 +: 32] + 32'd1;
        end
      end
      if (|(req_valid & ~grant_s)) begin
        perf_wait_r <= perf_wait_r + 32'd1;
      end
    end
  end

  assign perf_grant_cnt = perf_grant_r;
  assign perf_wait_cnt  = perf_wait_r;
`endif

  assign req_ready  = grant_s;
  assign unit_valid = unit_valid_r;
  assign unit_a     = unit_a_r;
  assign unit_b     = unit_b_r;
  assign unit_op    = unit_op_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign idle       = idle_r;
  assign err        = err_r;

endmodule

// File: tb/tb_fp_unit_sched.sv
// Directed testbench for fp_unit_sched (N_REQ=4, WIDTH=32, LATENCY=4).
// Cycle c of a test starts at a rising edge; inputs are driven 1ns after that
// edge and outputs are checked at the following falling edge. The shared FP
// unit is a stub delay line returning a+b+op, except for the 1.0+2.0 vector
// which returns 3.0 (0x40400000).
module tb_fp_unit_sched;
  import fp_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*2-1:0]   req_op;
  logic             unit_valid;
  logic [W-1:0]     unit_a;
  logic [W-1:0]     unit_b;
  logic [1:0]       unit_op;
  logic             unit_out_valid;
  logic [W-1:0]     unit_result;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             idle;
  logic             err;

  logic             spur;
  logic             drop;
  logic [L-1:0]     pv;
  logic [W-1:0]     pres [L];

  int checks = 0;
  int errors = 0;

  fp_unit_sched #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_op         (req_op),
    .unit_valid     (unit_valid),
    .unit_a         (unit_a),
    .unit_b         (unit_b),
    .unit_op        (unit_op),
    .unit_out_valid (unit_out_valid),
    .unit_result    (unit_result),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .idle           (idle),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] unit_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 2'd0) return 32'h4040_0000;
    return a + b + {30'd0, op};
  endfunction

  // Stub shared unit: fixed LATENCY delay, shares rst_n with the scheduler.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < L; k++) pres[k] <= '0;
    end else begin
      pv      <= {pv[L-2:0], unit_valid};
      pres[0] <= unit_model(unit_a, unit_b, unit_op);
      for (int k = 1; k < L; k++) pres[k] <= pres[k-1];
    end
  end

  assign unit_out_valid = (pv[L-1] & ~drop) | spur;
  assign unit_result    = pres[L-1];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0; req_valid = '0; en = 1'b1; spur = 1'b0; drop = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Standard operand set: results 0x110, 0x221, 0x332, 0x440.
  task automatic load_all();
    set_slot(0, 32'h100, 32'h10, 2'd0);
    set_slot(1, 32'h200, 32'h20, 2'd1);
    set_slot(2, 32'h300, 32'h30, 2'd2);
    set_slot(3, 32'h400, 32'h40, 2'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req_valid = '0; spur = 1'b0; drop = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    settle();
    checks++;
    if ({req_ready, unit_valid, unit_a, unit_b, unit_op, rsp_valid, rsp_data, idle, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b uv=%b ua=%h rv=%b rd=%h idle=%b err=%b, all required 0",
               req_ready, unit_valid, unit_a, rsp_valid, rsp_data, idle, err);
    end
    cyc(); rst_n = 1'b1; settle();
    checks++;
    if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got %b expected 0", idle); end
    cyc(); settle();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle_rise: got %b expected 1", idle); end
  endtask

  task automatic test_single_op();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c == 0) begin
        set_slot(0, 32'h3F80_0000, 32'h4000_0000, 2'd0);
        req_valid = 4'b0001;
      end else begin
        req_valid = 4'b0000;
      end
      settle();
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_c0: got %b expected 1", idle); end
      end
      if (c == 1) begin
        checks++;
        if ({unit_valid, unit_a, unit_b, unit_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'd0}) begin
          errors++;
          $display("FAIL single_issue: got v=%b a=%h b=%h op=%0d expected v=1 a=3f800000 b=40000000 op=0",
                   unit_valid, unit_a, unit_b, unit_op);
        end
      end
      if (c == 3) begin
        checks++;
        if ({unit_valid, idle} !== 2'b00) begin errors++; $display("FAIL single_busy: got uv=%b idle=%b expected 0 0", unit_valid, idle); end
      end
      if (c == 5) begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid); end
      end
      if (c == 6) begin
        checks++;
        if ({rsp_valid, rsp_data, idle} !== {4'b0001, 32'h4040_0000, 1'b0}) begin
          errors++;
          $display("FAIL single_rsp: got rv=%b rd=%h idle=%b expected 0001 40400000 0", rsp_valid, rsp_data, idle);
        end
      end
      if (c == 7) begin
        checks++;
        if ({rsp_valid, rsp_data, idle, err} !== {4'b0000, 32'h4040_0000, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL single_after: got rv=%b rd=%h idle=%b err=%b expected 0000 40400000 1 0",
                   rsp_valid, rsp_data, idle, err);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_res [4];
    logic [W-1:0] exp_a   [4];
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    exp_res = '{32'h110, 32'h221, 32'h332, 32'h440};
    exp_a   = '{32'h100, 32'h200, 32'h300, 32'h400};
    do_reset();
    load_all();
    for (int c = 0; c < 14; c++) begin
      cyc();
      req_valid = (c < 8) ? 4'hF : 4'h0;
      settle();
      exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      if (c >= 1 && c <= 8) begin
        checks++;
        if ({unit_valid, unit_a} !== {1'b1, exp_a[(c-1)%4]}) begin
          errors++;
          $display("FAIL rr_issue c%0d: got v=%b a=%h expected 1 %h", c, unit_valid, unit_a, exp_a[(c-1)%4]);
        end
      end
      if (c >= 6) begin
        exp_rv = 4'b0001 << ((c - 6) % 4);
        checks++;
        if ({rsp_valid, rsp_data} !== {exp_rv, exp_res[(c-6)%4]}) begin
          errors++;
          $display("FAIL rr_rsp c%0d: got rv=%b rd=%h expected %b %h", c, rsp_valid, rsp_data, exp_rv, exp_res[(c-6)%4]);
        end
      end else begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_early c%0d: got %b expected 0000", c, rsp_valid); end
      end
    end
  endtask

  // Runs right after test_round_robin: pointer sits at 0 after the grant to 3.
  task automatic test_pointer_wrap();
    for (int c = 0; c < 9; c++) begin
      cyc();
      req_valid = (c < 2) ? 4'b1001 : 4'b0000;
      settle();
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b expected 0001", req_ready); end
      end
      if (c == 1) begin
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b expected 1000", req_ready); end
      end
      if (c == 6) begin
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0001, 32'h110}) begin
          errors++; $display("FAIL wrap_rsp0: got %b %h expected 0001 00000110", rsp_valid, rsp_data);
        end
      end
      if (c == 7) begin
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b1000, 32'h440}) begin
          errors++; $display("FAIL wrap_rsp3: got %b %h expected 1000 00000440", rsp_valid, rsp_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_a [3];
    exp_a = '{32'h1000, 32'h2000, 32'h3000};
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c < 3) begin
        set_slot(1, exp_a[c], 32'h1, 2'd1);
        req_valid = 4'b0010;
      end else begin
        req_valid = 4'b0000;
      end
      settle();
      if (c < 3) begin
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant c%0d: got %b expected 0010", c, req_ready); end
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({unit_valid, unit_a, unit_op} !== {1'b1, exp_a[c-1], 2'd1}) begin
          errors++; $display("FAIL b2b_issue c%0d: got v=%b a=%h op=%0d expected 1 %h 1", c, unit_valid, unit_a, unit_op, exp_a[c-1]);
        end
      end
      if (c >= 6 && c <= 8) begin
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0010, exp_a[c-6] + 32'h2}) begin
          errors++; $display("FAIL b2b_rsp c%0d: got %b %h expected 0010 %h", c, rsp_valid, rsp_data, exp_a[c-6] + 32'h2);
        end
      end
      if (c == 9) begin
        checks++;
        if ({rsp_valid, idle} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL b2b_idle: got rv=%b idle=%b expected 0000 1", rsp_valid, idle); end
      end
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] exp_res [3];
    exp_res = '{32'h110, 32'h221, 32'h332};
    do_reset();
    load_all();
    for (int c = 0; c < 12; c++) begin
      cyc();
      req_valid = 4'hF;
      en = (c < 3 || c >= 10) ? 1'b1 : 1'b0;
      settle();
      if (c < 3) begin
        checks++;
        if (req_ready !== (4'b0001 << c)) begin errors++; $display("FAIL en_grant c%0d: got %b expected %b", c, req_ready, 4'b0001 << c); end
      end
      if (c >= 3 && c < 10) begin
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL en_blocked c%0d: got %b expected 0000", c, req_ready); end
      end
      if (c >= 4 && c < 10) begin
        checks++;
        if (unit_valid !== 1'b0) begin errors++; $display("FAIL en_no_issue c%0d: got %b expected 0", c, unit_valid); end
      end
      if (c >= 6 && c <= 8) begin
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0001 << (c - 6), exp_res[c-6]}) begin
          errors++; $display("FAIL en_rsp c%0d: got %b %h expected %b %h", c, rsp_valid, rsp_data, 4'b0001 << (c - 6), exp_res[c-6]);
        end
      end
      if (c == 8) begin
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL en_idle_c8: got %b expected 0", idle); end
      end
      if (c == 9) begin
        checks++;
        if ({idle, err} !== 2'b10) begin errors++; $display("FAIL en_idle_c9: got idle=%b err=%b expected 1 0", idle, err); end
      end
      if (c == 10) begin
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL en_resume: got %b expected 1000", req_ready); end
      end
      if (c == 11) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL en_resume_next: got %b expected 0001", req_ready); end
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc();
      spur = (c == 0) ? 1'b1 : 1'b0;
      settle();
      checks++;
      if (err !== ((c == 0) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL err_spurious c%0d: got %b expected %b", c, err, (c == 0) ? 1'b0 : 1'b1);
      end
    end
    do_reset();
    settle();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (c == 0) begin
        set_slot(2, 32'h5, 32'h6, 2'd0);
        req_valid = 4'b0100;
      end else begin
        req_valid = 4'b0000;
      end
      drop = (c == 5) ? 1'b1 : 1'b0;
      settle();
      if (c == 5) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_missing_pre: got %b expected 0", err); end
      end
      if (c == 6) begin
        checks++;
        if ({err, rsp_valid, rsp_data} !== {1'b1, 4'b0100, 32'hB}) begin
          errors++; $display("FAIL err_missing: got err=%b rv=%b rd=%h expected 1 0100 0000000b", err, rsp_valid, rsp_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    load_all();
    for (int c = 0; c < 12; c++) begin
      cyc();
      req_valid = (c < 2) ? 4'b0110 : ((c == 11) ? 4'hF : 4'h0);
      rst_n = (c == 2) ? 1'b0 : 1'b1;
      settle();
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_if_grant1: got %b expected 0010", req_ready); end
      end
      if (c == 1) begin
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_if_grant2: got %b expected 0100", req_ready); end
      end
      if (c == 2) begin
        checks++;
        if ({req_ready, unit_valid, unit_a, rsp_valid, rsp_data, idle, err} !== '0) begin
          errors++;
          $display("FAIL rst_if_outputs: got rdy=%b uv=%b ua=%h rv=%b rd=%h idle=%b err=%b, all required 0",
                   req_ready, unit_valid, unit_a, rsp_valid, rsp_data, idle, err);
        end
      end
      if (c >= 3 && c < 11) begin
        checks++;
        if ({rsp_valid, err} !== 5'b0) begin errors++; $display("FAIL rst_if_no_rsp c%0d: got rv=%b err=%b expected 0000 0", c, rsp_valid, err); end
      end
      if (c == 11) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_if_ptr: got %b expected 0001", req_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_pointer_wrap();
    test_back_to_back();
    test_enable();
    test_err();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
